// File: rtl/mem_sequencer_if.sv
// Host request/response channel plus memory-controller command bus for
// mem_sequencer. master = host/memory side, slave = the sequencer itself.
interface mem_sequencer_if #(
    parameter int ADDR_BITS = 2
);
    // Host request channel
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [ADDR_BITS-1:0] req_addr;
    logic [7:0]           req_data;
    logic [ADDR_BITS-1:0] req_len;

    // Host response channel
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic                 rsp_last;

    // Memory-controller command bus
    logic [ADDR_BITS-1:0] mc_addr;
    logic [7:0]           mc_data;
    logic [3:0]           mc_inst;
    logic [7:0]           mc_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_data, req_len,
        output rsp_ready, mc_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
        input  mc_addr, mc_data, mc_inst
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_len,
        input  rsp_ready, mc_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_last,
        output mc_addr, mc_data, mc_inst
    );
endinterface

// File: rtl/mem_sequencer.sv
// Memory sequencer: turns single host requests (WRITE/READ/FILL/DUMP) into
// memory-controller instruction sequences and returns read data one word at
// a time over a valid/ready response channel. All outputs are registered.
module mem_sequencer #(
    parameter int ADDR_BITS = 2
) (
    input  logic             clock,
    input  logic             reset,
    mem_sequencer_if.slave   bus,
    output logic             busy
);
    localparam int CW = ADDR_BITS + 1;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_DUMP  = 2'd3;

    localparam logic [3:0] MC_IDLE  = 4'd0;
    localparam logic [3:0] MC_WRITE = 4'd1;
    localparam logic [3:0] MC_READ  = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_FILL     = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    state_t               state_r, state_nx_s;
    logic [ADDR_BITS-1:0] addr_r, addr_nx_s;
    logic [CW-1:0]        cnt_r, cnt_nx_s;
    logic [7:0]           data_r, data_nx_s;

    logic [3:0]           mc_inst_r, mc_inst_nx_s;
    logic [ADDR_BITS-1:0] mc_addr_r, mc_addr_nx_s;
    logic [7:0]           mc_data_r, mc_data_nx_s;
    logic                 rsp_valid_r, rsp_valid_nx_s;
    logic [7:0]           rsp_data_r, rsp_data_nx_s;
    logic                 rsp_last_r, rsp_last_nx_s;
    logic                 req_ready_r, req_ready_nx_s;
    logic                 busy_r, busy_nx_s;

    logic                 accept_s;
    logic [CW-1:0]        len_ext_s;
    logic                 cnt_one_s;

    // A length of 0 encodes a full sweep of the memory.
    assign len_ext_s = (bus.req_len == {ADDR_BITS{1'b0}}) ? {1'b1, {ADDR_BITS{1'b0}}}
                                                          : {1'b0, bus.req_len};
    assign accept_s  = bus.req_valid & req_ready_r;
    assign cnt_one_s = (cnt_r == CW'(1));

    // State register, latched request fields and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_BITS{1'b0}};
            cnt_r       <= {CW{1'b0}};
            data_r      <= 8'h00;
            mc_inst_r   <= MC_IDLE;
            mc_addr_r   <= {ADDR_BITS{1'b0}};
            mc_data_r   <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_last_r  <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            addr_r      <= addr_nx_s;
            cnt_r       <= cnt_nx_s;
            data_r      <= data_nx_s;
            mc_inst_r   <= mc_inst_nx_s;
            mc_addr_r   <= mc_addr_nx_s;
            mc_data_r   <= mc_data_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_data_r  <= rsp_data_nx_s;
            rsp_last_r  <= rsp_last_nx_s;
            req_ready_r <= req_ready_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    // Next-state logic: request acceptance, address stepping, word counting.
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        cnt_nx_s   = cnt_r;
        data_nx_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_nx_s = bus.req_addr;
                    data_nx_s = bus.req_data;
                    case (bus.req_op)
                        OP_WRITE: begin state_nx_s = ST_WR;       cnt_nx_s = CW'(1);    end
                        OP_READ:  begin state_nx_s = ST_RD_ISSUE; cnt_nx_s = CW'(1);    end
                        OP_FILL:  begin state_nx_s = ST_FILL;     cnt_nx_s = len_ext_s; end
                        OP_DUMP:  begin state_nx_s = ST_RD_ISSUE; cnt_nx_s = len_ext_s; end
                        default:  begin state_nx_s = ST_IDLE;     cnt_nx_s = cnt_r;     end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WR: begin
                state_nx_s = ST_IDLE;
            end
            ST_FILL: begin
                if (cnt_one_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FILL;
                    addr_nx_s  = addr_r + ADDR_BITS'(1);
                    cnt_nx_s   = cnt_r - CW'(1);
                end
            end
            ST_RD_ISSUE: begin
                state_nx_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_nx_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (cnt_one_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RD_ISSUE;
                        addr_nx_s  = addr_r + ADDR_BITS'(1);
                        cnt_nx_s   = cnt_r - CW'(1);
                    end
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the
    // next state so each output lines up with the state it belongs to.
    always_comb begin
        mc_inst_nx_s   = MC_IDLE;
        mc_addr_nx_s   = mc_addr_r;
        mc_data_nx_s   = mc_data_r;
        rsp_valid_nx_s = 1'b0;
        case (state_nx_s)
            ST_WR, ST_FILL: begin
                mc_inst_nx_s = MC_WRITE;
                mc_addr_nx_s = addr_nx_s;
                mc_data_nx_s = data_nx_s;
            end
            ST_RD_ISSUE: begin
                mc_inst_nx_s = MC_READ;
                mc_addr_nx_s = addr_nx_s;
            end
            ST_RESP: begin
                rsp_valid_nx_s = 1'b1;
            end
            default: begin
                mc_inst_nx_s = MC_IDLE;
            end
        endcase
        // Controller read data is valid during RD_CAP; capture it at its end.
        if (state_r == ST_RD_CAP) begin
            rsp_data_nx_s = bus.mc_rdata;
            rsp_last_nx_s = cnt_one_s;
        end else begin
            rsp_data_nx_s = rsp_data_r;
            rsp_last_nx_s = rsp_last_r;
        end
        busy_nx_s      = (state_nx_s != ST_IDLE);
        req_ready_nx_s = (state_nx_s == ST_IDLE);
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_last  = rsp_last_r;
    assign bus.mc_inst   = mc_inst_r;
    assign bus.mc_addr   = mc_addr_r;
    assign bus.mc_data   = mc_data_r;
    assign busy          = busy_r;
endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 2, meaning the memory address width; depth is 2**ADDR_BITS words of 8 bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  host request present.
REQ-005 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port req_op  input  2  0=WRITE, 1=READ, 2=FILL, 3=DUMP.
REQ-007 SHALL have port req_addr  input  ADDR_BITS  start address.
REQ-008 SHALL have port req_data  input  8  write/fill data.
REQ-009 SHALL have port req_len  input  ADDR_BITS  FILL/DUMP word count; 0 means 2**ADDR_BITS.
REQ-010 SHALL have port rsp_valid  output  1  read data present.
REQ-011 SHALL have port rsp_ready  input  1  host accepts read data.
REQ-012 SHALL have port rsp_data  output  8  read data.
REQ-013 SHALL have port rsp_last  output  1  final word of READ/DUMP, qualified by rsp_valid.
REQ-014 SHALL have port mc_addr  output  ADDR_BITS  address to memory controller.
REQ-015 SHALL have port mc_data  output  8  write data to memory controller.
REQ-016 SHALL have port mc_inst  output  4  controller instruction: 0 idle, 1 write, 2 read; no other code is ever driven.
REQ-017 SHALL have port mc_rdata  input  8  controller registered read output.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, WR, FILL, RD_ISSUE, RD_CAP, RESP; all outputs registered or decoded from state only.
REQ-020 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready at a rising edge, which latches op, addr, data, len.
REQ-021 WRITE: SHALL go IDLE->WR; in WR drive mc_inst=1, mc_addr=latched addr, mc_data=latched data for exactly one cycle; then IDLE; no response.
REQ-022 FILL: SHALL go IDLE->FILL; drive mc_inst=1 with mc_data=latched data for len consecutive cycles, mc_addr incrementing by 1 mod 2**ADDR_BITS each cycle; then IDLE; no response.
REQ-023 READ/DUMP: SHALL go IDLE->RD_ISSUE (mc_inst=2, mc_addr=current addr, one cycle) ->RD_CAP (mc_inst=0; rsp_data<=mc_rdata at end of cycle) ->RESP.
REQ-024 In RESP SHALL hold rsp_valid=1 with rsp_data and rsp_last stable until rsp_valid & rsp_ready at a rising edge.
REQ-025 rsp_valid SHALL first be high in the third cycle after the accepting edge (READ latency 3 cycles to data presented).
REQ-026 On RESP handshake SHALL go to IDLE if the word was last, else increment address mod 2**ADDR_BITS, decrement remaining count, and go to RD_ISSUE.
REQ-027 rsp_last SHALL be 1 for READ, and for DUMP only on the len-th word.
REQ-028 Address wrap past 2**ADDR_BITS-1 SHALL continue at 0 with no error or stall.
REQ-029 Outside WR/FILL/RD_ISSUE, mc_inst SHALL be 0; mc_addr/mc_data hold last values.
REQ-030 Requests presented while busy SHALL be ignored (not accepted, not queued).

Reset
REQ-031 On reset low, asynchronously: state=IDLE, mc_inst=0, mc_addr=0, mc_data=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, req_ready=0 while reset low, 1 from the first edge after release.
REQ-032 Reset mid-FILL/DUMP SHALL abort immediately; memory contents are not cleared; no partial response issued after release.

Verification
REQ-033 WRITE addr=2 data=0xA5, then READ addr=2 -> mc_inst=1 one cycle at addr 2; rsp_data=0xA5, rsp_last=1, rsp_valid in third cycle after accept.
REQ-034 FILL addr=3 len=0 data=0x3C (ADDR_BITS=2) -> 4 write cycles at addrs 3,0,1,2; DUMP addr=0 len=0 -> 4 responses 0x3C, rsp_last only on 4th.
REQ-035 DUMP len=2 with rsp_ready low 5 cycles on word 1 -> rsp_valid/rsp_data held stable 5 cycles, no mc_inst=2 issued until handshake.
REQ-036 req_valid held high during a FILL with different op -> not accepted until busy=0; then accepted exactly once.
REQ-037 Reset asserted mid-DUMP at word 2 -> mc_inst=0, rsp_valid=0 immediately, busy=0; after release READ returns previously written data.
